// File: rtl/uart_pkg.sv
// Shared state type, line levels and bit-period helper for the UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

   // Clock cycles per line bit; the remainder of the division is dropped.
   function automatic int calc_pulse_width(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO: rdata always shows the oldest entry while count != 0.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               wdata,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; queued words leave back-to-back with no idle gap.
// Define UART_TX_PARITY_EN to insert a parity bit (polarity PARITY_ODD) after the data bits.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 115200,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [DATA_WIDTH-1:0]             data,
   input  logic                              valid,
   output logic                              ready,
   output logic                              uart_out,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
   localparam int PULSE_WIDTH = calc_pulse_width(CLK_FREQ, BAUD_RATE);
   localparam int TW = (PULSE_WIDTH > 2) ? $clog2(PULSE_WIDTH) : 1;
   localparam int IW = $clog2(DATA_WIDTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [TW-1:0] PW_LOAD   = TW'(PULSE_WIDTH - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_WIDTH - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   if (PULSE_WIDTH < 2) begin : g_chk_pw
      $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_chk_width
      $error("uart_tx_fifo: DATA_WIDTH must be 5..9");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
      $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
   end

   tx_state_t             state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [IW-1:0]         bit_idx_q, bit_idx_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  uart_out_q, uart_out_d;
   logic                  ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_full, fifo_empty;
   logic                  push, pop, load, bit_done;
   logic [CW-1:0]         count_next;

   uart_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .wdata (data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      load       = 1'b0;
      bit_done   = (timer_q == '0);
      timer_d    = bit_done ? PW_LOAD : timer_q - TW'(1);
      case (state_q)
         IDLE:  load = !fifo_empty;
         START: if (bit_done) begin
            state_d   = DATA;
            bit_idx_d = '0;
         end
         DATA: if (bit_done) begin
            if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
               stop_cnt_d = 1'b0;
            end else begin
               bit_idx_d = bit_idx_q + IW'(1);
               shift_d   = shift_q >> 1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_done) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
         end
`endif
         STOP: if (bit_done) begin
            if (stop_cnt_q == LAST_STOP) begin
               state_d = IDLE;
               load    = !fifo_empty;
            end else begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Popping and latching the next word share one path for IDLE and end-of-stop.
      if (load) begin
         state_d = START;
         shift_d = fifo_rdata;
         timer_d = PW_LOAD;
      end
      pop = load;
   end

`ifdef UART_TX_PARITY_EN
   always_comb begin
      parity_d = parity_q;
      if (load) begin
         parity_d = (^fifo_rdata) ^ 1'(PARITY_ODD);
      end
   end
`endif

   // The line is registered from the next-state view so it changes on the transition edge.
   always_comb begin
      case (state_d)
         START:   uart_out_d = UART_START_LEVEL;
         DATA:    uart_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  uart_out_d = parity_d;
`endif
         default: uart_out_d = UART_IDLE_LEVEL;
      endcase
   end

   assign push       = valid && ready_q && !fifo_full;
   assign count_next = fifo_count + CW'(push) - CW'(pop);
   assign ready_d    = (count_next != CW'(FIFO_DEPTH));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         uart_out_q <= UART_IDLE_LEVEL;
         ready_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         uart_out_q <= uart_out_d;
         ready_q    <= ready_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign uart_out = uart_out_q;
   assign ready    = ready_q;
   assign busy     = (state_q != IDLE);

endmodule
